// File: rtl/br_resolve.sv
// Execute-stage branch resolution: resolves direction/target, checks the fetch prediction,
// registers the result and pulses a fetch redirect. Optional counters under BR_PERF_CTR_EN.
module br_resolve #(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1_v,
  input  logic [31:0]      in_rs2_v,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_cmpop,
  input  logic [1:0]       in_kind,
  input  logic             in_pred_taken,
  input  logic [31:0]      in_pred_target,
  input  logic             in_epoch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_target,
  output logic [31:0]      out_link,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_misaligned,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CTR_W-1:0] perf_br_cnt,
  output logic [CTR_W-1:0] perf_mp_cnt
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e      state_q, state_d;
  logic        epoch_q;
  logic [31:0] pc_q, target_q, link_q;
  logic        taken_q, mp_q, mis_q, redir_q;

  logic        resTaken, resMis, resMp;
  logic [31:0] resTarget, resLink;
  logic        stale, liveAcc;

  // RV32I branch comparator; the two reserved funct3 codes never take.
  function automatic logic cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  cmp = (a == b);
      3'b001:  cmp = (a != b);
      3'b100:  cmp = ($signed(a) <  $signed(b));
      3'b101:  cmp = ($signed(a) >= $signed(b));
      3'b110:  cmp = (a <  b);
      3'b111:  cmp = (a >= b);
      default: cmp = 1'b0;
    endcase
  endfunction

  always_comb begin
    resLink   = in_pc + 32'd4;
    resTaken  = 1'b0;
    resTarget = resLink;
    case (in_kind)
      2'b01: begin
        resTaken  = cmp(in_cmpop, in_rs1_v, in_rs2_v);
        resTarget = in_pc + in_imm;
      end
      2'b10: begin
        resTaken  = 1'b1;
        resTarget = in_pc + in_imm;
      end
      2'b11: begin
        resTaken  = 1'b1;
        resTarget = (in_rs1_v + in_imm) & ~32'd1;
      end
      default: ;
    endcase
    resMis = resTaken & resTarget[1];
    resMp  = !resMis && ((resTaken != in_pred_taken) ||
                         (resTaken && (resTarget != in_pred_target)));
  end

  // Wrong-path ops are always swallowed so the front end never stalls on them.
  assign stale    = (in_epoch != epoch_q);
  assign in_ready = stale || (state_q == EMPTY) || out_ready;
  assign liveAcc  = in_valid && !stale && ((state_q == EMPTY) || out_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (liveAcc) state_d = FULL;
      FULL:    if (out_ready && !liveAcc) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      epoch_q  <= 1'b0;
      pc_q     <= '0;
      target_q <= '0;
      link_q   <= '0;
      taken_q  <= 1'b0;
      mp_q     <= 1'b0;
      mis_q    <= 1'b0;
      redir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      redir_q <= liveAcc && resMp;
      if (liveAcc) begin
        pc_q     <= in_pc;
        target_q <= resTarget;
        link_q   <= resLink;
        taken_q  <= resTaken;
        mp_q     <= resMp;
        mis_q    <= resMis;
        if (resMp) epoch_q <= ~epoch_q;
      end
    end
  end

  assign out_valid      = (state_q == FULL);
  assign out_pc         = pc_q;
  assign out_target     = target_q;
  assign out_link       = link_q;
  assign out_taken      = taken_q;
  assign out_mispredict = mp_q;
  assign out_misaligned = mis_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = taken_q ? target_q : link_q;

`ifdef BR_PERF_CTR_EN
  logic [CTR_W-1:0] brCnt_q, mpCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brCnt_q <= '0;
      mpCnt_q <= '0;
    end else if (liveAcc) begin
      if (in_kind != 2'b00) brCnt_q <= brCnt_q + 1'b1;
      if (resMp)            mpCnt_q <= mpCnt_q + 1'b1;
    end
  end

  assign perf_br_cnt = brCnt_q;
  assign perf_mp_cnt = mpCnt_q;
`else
  assign perf_br_cnt = '0;
  assign perf_mp_cnt = '0;
`endif

endmodule

// File: doc/br_resolve.md
# br_resolve

Execute-stage branch resolution register. It sits directly downstream of the operand read stage and wraps the `cmp` comparator. Each cycle it evaluates one control-transfer op and computes its actual direction and target. It checks that outcome against the fetch-time prediction, registers the result for writeback/commit, and issues a single-cycle fetch redirect on mispredict. An epoch bit lets it squash wrong-path ops that are already in flight.

## Interface
Parameters
- CTR_W, default 32: width of the performance counters.

Ports
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  upstream op accepted when in_valid && in_ready.
- in_pc  in  32  op PC.
- in_rs1_v, in_rs2_v  in  32  operand values.
- in_imm  in  32  sign-extended immediate.
- in_cmpop  in  3  RV32I funct3: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111.
- in_kind  in  2  00 non-control, 01 branch, 10 jal, 11 jalr.
- in_pred_taken  in  1  fetch prediction.
- in_pred_target  in  32  fetch predicted target.
- in_epoch  in  1  fetch epoch tag of the op.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- out_pc, out_target, out_link  out  32  registered PC, resolved target, pc+4.
- out_taken, out_mispredict, out_misaligned  out  1  resolved flags.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  32  correct next PC.
- perf_br_cnt, perf_mp_cnt  out  CTR_W  resolved-branch and mispredict counters.

## Operation
- Combinational resolve on the input side.
  - branch: taken = cmp(in_cmpop, rs1, rs2); target = pc+imm.
  - jal: taken = 1; target = pc+imm.
  - jalr: taken = 1; target = (rs1+imm) & ~1.
  - non-control: taken = 0; target = pc+4.
- All address arithmetic is 32-bit modulo (wraps).
- An undefined cmpop (010/011) on a branch resolves not-taken.
- misaligned = taken && target[1].
- mispredict = !misaligned && (taken != pred_taken || (taken && target != pred_target)).
- Internal state: cur_epoch (1 bit) and a one-entry output register with valid bit; the FSM is EMPTY ↔ FULL.
- Stale op (in_epoch != cur_epoch):
  - in_ready = 1 regardless of the output register.
  - The op is accepted and discarded: no register load, no counters, no redirect.
- Live op: in_ready = !out_valid || out_ready. On accept:
  - The output register loads.
  - cur_epoch toggles if the op mispredicts.
- EMPTY→FULL on live accept. FULL→EMPTY on out_ready with no live accept. FULL→FULL on simultaneous drain and live accept (full throughput).
- redirect_pc = out_taken ? out_target : out_link.

## Timing
- Latency: accept at edge N → out_valid, results and redirect visible in cycle N+1.
- redirect_valid is high only in the first cycle a mispredicting entry is held. It stays a single pulse even if out_ready stalls the entry.
- An op presented in the redirect cycle with the old epoch is dropped.
- Reset (asynchronous, immediate):
  - out_valid = 0, redirect_valid = 0, cur_epoch = 0.
  - All data outputs = 0, counters = 0.
- Reset mid-stall discards the held entry; no redirect is emitted after deassertion.
- Outputs hold stable while out_valid && !out_ready.

## Configuration
- BR_PERF_CTR_EN defined:
  - perf_br_cnt increments on each live accepted op with kind != 00.
  - perf_mp_cnt increments on each live accepted mispredict.
  - Both counters wrap at 2^CTR_W.
- BR_PERF_CTR_EN undefined: both ports are driven constant 0 and no counter flops are synthesized.

## Test plan
- bne x≠y, pc=0x100, imm=0x20, pred not-taken, epoch 0 → next cycle out_taken=1, out_mispredict=1, redirect_valid pulse with redirect_pc=0x120; cur_epoch becomes 1.
- After that redirect, two ops with epoch 0 followed by one with epoch 1 → epoch-0 ops accepted with in_ready=1 and never appear on out_valid; the epoch-1 op appears.
- blt -1 vs 1 (taken) vs bltu same operands (not taken), both predicted correctly → no redirect, out_mispredict=0 both.
- jalr rs1=0x1003, imm=0 → target 0x1002, misaligned=1, mispredict=0, no redirect; jalr rs1=0x2001, imm=0 → target 0x2000, misaligned=0.
- Mispredict held with out_ready=0 for 5 cycles → redirect_valid high exactly 1 cycle, outputs stable, in_ready=0 for live ops.
- With BR_PERF_CTR_EN: 3 branches (1 mispredict) plus 1 non-control op → perf_br_cnt=3, perf_mp_cnt=1; assert rst mid-sequence → both counters are 0 immediately.
